// File: rtl/cpu_control_pipe.sv
// cpu_control_pipe: registered LEGv8 main-control decoder for the decode stage.
// Accepts inst[31:21] over a valid/ready handshake and emits one registered
// control bundle per accepted opcode, with flush, a RUN/HALTED/TRAP state
// machine and a saturating illegal-opcode counter.
// Optional feature macro: CTRL_BL_EN (decode BL and drive Link).
module cpu_control_pipe #(
  parameter int OPC_W       = 11,
  parameter int ALUOP_W     = 2,
  parameter int ILL_CNT_W   = 8,
  parameter int TRAP_ON_ILL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPC_W-1:0]     inst31_21,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush,
  input  logic                 resume,
  output logic                 Reg2Loc,
  output logic                 Branch,
  output logic                 BranchZero,
  output logic                 BranchNonZero,
  output logic                 MemRead,
  output logic                 MemtoReg,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [ALUOP_W-1:0]   ALUOp,
  output logic [1:0]           ALUSrc,
  output logic                 Link,
  output logic                 halted,
  output logic                 trap,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

`ifdef CTRL_BL_EN
  localparam bit BL_EN = 1'b1;
`else
  localparam bit BL_EN = 1'b0;
`endif

  localparam logic [10:0] OP_NOP  = 11'b11010101000;
  localparam logic [10:0] OP_HALT = 11'b11111111111;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [5:0]  OP_BL   = 6'b100101;

  localparam logic [ILL_CNT_W-1:0] CNT_ONE = ILL_CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_TRAP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Opcode compares always look at the top 11 bits of the field
  logic [10:0] w_opc;
  assign w_opc = inst31_21[OPC_W-1 -: 11];

  // Decoded (combinational) control bundle
  logic       w_reg2loc;
  logic       w_branch;
  logic       w_bzero;
  logic       w_bnzero;
  logic       w_memread;
  logic       w_memtoreg;
  logic       w_memwrite;
  logic       w_regwrite;
  logic [1:0] w_aluop;
  logic [1:0] w_alusrc;
  logic       w_link;
  logic       w_illegal;
  logic       w_is_halt;

  // Registered control bundle
  logic               r_vld_p1;
  logic               r_reg2loc_p1;
  logic               r_branch_p1;
  logic               r_bzero_p1;
  logic               r_bnzero_p1;
  logic               r_memread_p1;
  logic               r_memtoreg_p1;
  logic               r_memwrite_p1;
  logic               r_regwrite_p1;
  logic [ALUOP_W-1:0] r_aluop_p1;
  logic [1:0]         r_alusrc_p1;
  logic               r_link_p1;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  logic w_accept;
  logic w_fire;
  logic w_cnt_sat;

  // Nothing is accepted while reset is asserted, so ready is gated by it too
  assign in_ready  = rst_n && (r_state == S_RUN) && (!r_vld_p1 || out_ready);
  assign w_accept  = in_valid && in_ready;
  // A same-cycle flush discards the incoming opcode entirely
  assign w_fire    = w_accept && !flush;
  assign w_cnt_sat = &r_ill_cnt;
  assign w_is_halt = (w_opc == OP_HALT);

  // Priority decode: full match, then [10:1], [10:3], [10:5]; anything else is illegal
  always_comb begin
    w_reg2loc  = 1'b0;
    w_branch   = 1'b0;
    w_bzero    = 1'b0;
    w_bnzero   = 1'b0;
    w_memread  = 1'b0;
    w_memtoreg = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_aluop    = 2'b00;
    w_alusrc   = 2'b00;
    w_link     = 1'b0;
    w_illegal  = 1'b0;
    if ((w_opc == OP_NOP) || (w_opc == OP_HALT)) begin
      w_illegal = 1'b0;
    end else if (w_opc == OP_LDUR) begin
      w_memread  = 1'b1;
      w_memtoreg = 1'b1;
      w_regwrite = 1'b1;
      w_alusrc   = 2'b01;
    end else if (w_opc == OP_STUR) begin
      w_reg2loc  = 1'b1;
      w_memwrite = 1'b1;
      w_alusrc   = 2'b01;
    end else if ((w_opc == OP_ADD) || (w_opc == OP_SUB) ||
                 (w_opc == OP_AND) || (w_opc == OP_ORR)) begin
      w_regwrite = 1'b1;
      w_aluop    = 2'b10;
    end else if (w_opc[10:1] == OP_ADDI) begin
      w_regwrite = 1'b1;
      w_alusrc   = 2'b10;
      w_aluop    = 2'b10;
    end else if (w_opc[10:3] == OP_CBZ) begin
      w_reg2loc = 1'b1;
      w_bzero   = 1'b1;
      w_aluop   = 2'b01;
    end else if (w_opc[10:3] == OP_CBNZ) begin
      w_reg2loc = 1'b1;
      w_bnzero  = 1'b1;
      w_aluop   = 2'b01;
    end else if (w_opc[10:5] == OP_B) begin
      w_branch = 1'b1;
    end else if (BL_EN && (w_opc[10:5] == OP_BL)) begin
      w_branch   = 1'b1;
      w_link     = 1'b1;
      w_regwrite = 1'b1;
    end else begin
      w_illegal = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: HALT/illegal leave RUN, resume brings HALTED/TRAP back
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_fire) begin
          if (w_is_halt) begin
            w_state_nxt = S_HALTED;
          end else if (w_illegal && (TRAP_ON_ILL != 0)) begin
            w_state_nxt = S_TRAP;
          end
        end
      end
      S_HALTED, S_TRAP: begin
        if (resume) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output stage: bundle loads on accept and holds under backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1      <= 1'b0;
      r_reg2loc_p1  <= 1'b0;
      r_branch_p1   <= 1'b0;
      r_bzero_p1    <= 1'b0;
      r_bnzero_p1   <= 1'b0;
      r_memread_p1  <= 1'b0;
      r_memtoreg_p1 <= 1'b0;
      r_memwrite_p1 <= 1'b0;
      r_regwrite_p1 <= 1'b0;
      r_aluop_p1    <= '0;
      r_alusrc_p1   <= 2'b00;
      r_link_p1     <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
    end else if (w_accept) begin
      r_vld_p1      <= 1'b1;
      r_reg2loc_p1  <= w_reg2loc;
      r_branch_p1   <= w_branch;
      r_bzero_p1    <= w_bzero;
      r_bnzero_p1   <= w_bnzero;
      r_memread_p1  <= w_memread;
      r_memtoreg_p1 <= w_memtoreg;
      r_memwrite_p1 <= w_memwrite;
      r_regwrite_p1 <= w_regwrite;
      r_aluop_p1    <= ALUOP_W'(w_aluop);
      r_alusrc_p1   <= w_alusrc;
      r_link_p1     <= w_link;
    end else if (out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  // Illegal-opcode counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_fire && w_illegal && !w_cnt_sat) begin
      r_ill_cnt <= r_ill_cnt + CNT_ONE;
    end
  end

  assign out_valid     = r_vld_p1;
  assign Reg2Loc       = r_reg2loc_p1;
  assign Branch        = r_branch_p1;
  assign BranchZero    = r_bzero_p1;
  assign BranchNonZero = r_bnzero_p1;
  assign MemRead       = r_memread_p1;
  assign MemtoReg      = r_memtoreg_p1;
  assign MemWrite      = r_memwrite_p1;
  assign RegWrite      = r_regwrite_p1;
  assign ALUOp         = r_aluop_p1;
  assign ALUSrc        = r_alusrc_p1;
  assign Link          = r_link_p1;
  assign halted        = (r_state == S_HALTED);
  assign trap          = (r_state == S_TRAP);
  assign ill_cnt       = r_ill_cnt;

endmodule
